// File: rtl/array_sort_writer_if.sv
// Host-side bundle for array_sort_writer: go/done handshake, array
// descriptor and the external register-file access port.
interface array_sort_writer_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;

  logic             go;
  logic [AW-1:0]    array;
  logic [AW-1:0]    length;
  logic             ext_we;
  logic [AW-1:0]    ext_addr;
  logic [WIDTH-1:0] ext_wdata;
  logic [WIDTH-1:0] ext_rdata;
  logic             busy;
  logic             done;
  logic [CW-1:0]    swap_count;

  modport master (
    output go, array, length, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, busy, done, swap_count
  );

  modport slave (
    input  go, array, length, ext_we, ext_addr, ext_wdata,
    output ext_rdata, busy, done, swap_count
  );
endinterface

// File: rtl/array_sort_writer.sv
// Sequential bubble sorter over a 32-entry register file. One compare per
// cycle; passes shrink by one and stop early when a pass makes no swap.
// Optional feature macro: ARRAY_SORT_SWAP_COUNT_EN builds the saturating
// 16-bit swap counter; without it swap_count is tied to zero.
module array_sort_writer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  array_sort_writer_if.slave    bus
);
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = 16;

  typedef enum logic [1:0] {IDLE, SCAN, PASS_END, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          swapped_q, swapped_d;
  logic          busy_q, done_q;

  logic [WIDTH-1:0] r [DEPTH];

  logic [AW-1:0]    idx_p1;
  logic [WIDTH-1:0] a, b;
  logic             swap_c;
  logic             start_c;

  assign idx_p1  = idx_q + AW'(1);
  assign a       = r[idx_q];
  assign b       = r[idx_p1];
  assign swap_c  = (state_q == SCAN) && (a > b);
  assign start_c = (state_q == IDLE) && bus.go;

  assign bus.ext_rdata = r[bus.ext_addr];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Control registers; synchronous active-low reset returns to IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      swapped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      swapped_q <= swapped_d;
      busy_q    <= (state_d == SCAN) || (state_d == PASS_END);
      done_q    <= (state_d == DONE);
    end
  end

  // Next-state and pass bookkeeping.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    swapped_d = swapped_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          base_d = bus.array;
          if (bus.length <= AW'(1)) begin
            state_d = DONE;
          end else begin
            idx_d     = bus.array;
            last_d    = bus.length - AW'(1);
            cnt_d     = '0;
            swapped_d = 1'b0;
            state_d   = SCAN;
          end
        end
      end
      SCAN: begin
        if (swap_c) swapped_d = 1'b1;
        idx_d = idx_p1;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q + AW'(1) == last_q) state_d = PASS_END;
      end
      PASS_END: begin
        if (!swapped_q || last_q == AW'(1)) begin
          state_d = DONE;
        end else begin
          last_d    = last_q - AW'(1);
          idx_d     = base_q;
          cnt_d     = '0;
          swapped_d = 1'b0;
          state_d   = SCAN;
        end
      end
      DONE: begin
        if (!bus.go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file: swap writes while sorting, host writes only when idle.
  // Contents are deliberately not reset; a swap on a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (swap_c && reset) begin
      r[idx_q]  <= b;
      r[idx_p1] <= a;
    end else if (bus.ext_we && !busy_q) begin
      r[bus.ext_addr] <= bus.ext_wdata;
    end
  end

`ifdef ARRAY_SORT_SWAP_COUNT_EN
  logic [CW-1:0] swap_count_q;

  // Saturating swap counter, cleared on each start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      swap_count_q <= '0;
    end else if (start_c) begin
      swap_count_q <= '0;
    end else if (swap_c && swap_count_q != {CW{1'b1}}) begin
      swap_count_q <= swap_count_q + CW'(1);
    end
  end

  assign bus.swap_count = swap_count_q;
`else
  logic unused_start;
  assign unused_start   = start_c;
  assign bus.swap_count = '0;
`endif

endmodule

// File: doc/array_sort_writer.md
# array_sort_writer

Sequential bubble sorter that owns a 32 × 32-bit register file and rewrites an array stored in it into non-decreasing unsigned order. It is the writing counterpart of the array sort checker: the checker only reads the register file and reports whether an array is sorted, while this block mutates the register file until the checker would report sorted. A testbench or host preloads and inspects contents through a single external port. Sorting runs one compare per cycle under go/done control.

## Interface
- `WIDTH`, 32: data width of each register-file entry.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `go`  in  1  start request; sampled in IDLE only.
- `array`  in  5  base index of the array; captured on start.
- `length`  in  5  element count, 0–31; captured on start.
- `ext_we`  in  1  external write enable; honoured only when `busy`=0.
- `ext_addr`  in  5  external write/read index.
- `ext_wdata`  in  WIDTH  external write data.
- `ext_rdata`  out  WIDTH  combinational `r[ext_addr]`; valid in every state.
- `busy`  out  1  high in SCAN and PASS_END.
- `done`  out  1  high in DONE.
- `swap_count`  out  16  total swaps in the current or last sort; see Configuration.

## Operation
- Storage `r[0:31]` is not cleared by reset. Contents survive reset, including a partially sorted array.
- Reset values: state=IDLE, `busy`=0, `done`=0, `swap_count`=0, `idx`=0, `last`=0, `swapped`=0.
- IDLE: if `go`=1, capture `base`=`array` and `len`=`length`.
  - If `len`≤1, go to DONE.
  - Otherwise set `idx`=`base`, `last`=`len`−1 (the number of compares in this pass), `cnt`=0, `swapped`=0, and go to SCAN.
- SCAN: compare `a`=`r[idx]` with `b`=`r[idx+1]`. All index arithmetic is 5-bit and wraps modulo 32 (31+1=0).
  - If `a`>`b` (unsigned), write `r[idx]`←`b` and `r[idx+1]`←`a` on the same edge, set `swapped`=1, and increment `swap_count`.
  - Then `idx`←`idx`+1 and `cnt`←`cnt`+1. When `cnt`+1=`last`, go to PASS_END.
- PASS_END:
  - If `swapped`=0 or `last`=1, go to DONE.
  - Otherwise `last`←`last`−1, `idx`←`base`, `cnt`←0, `swapped`←0, and return to SCAN.
- DONE: `done`=1. It holds while `go`=1; when `go`=0, go to IDLE. `swap_count` holds its value until the next start, which clears it.
- `ext_we` while `busy`=1 is dropped silently and has no effect on the sort.
- A `go` pulse seen outside IDLE is ignored.
- Reset asserted mid-sort forces IDLE on that edge. A swap write coincident with the reset edge is suppressed.

## Timing
- Start: `go` sampled at edge E0 means `busy`=1 from E0.
- Each pass with `last`=k takes k SCAN cycles plus 1 PASS_END cycle.
- For an already sorted n-element array (n≥2), `done` rises at edge E0+n. Example: n=5 gives 4 SCAN, 1 PASS_END, then DONE at E0+5.
- For `len`≤1, `done` rises at E0 with no writes.
- Worst case for n elements: Σ_{k=1}^{n−1}(k+1) cycles.
- A swap result is readable on `ext_rdata` in the cycle after the swap edge.
- An external write lands on the edge where it is sampled; it reads back in the next cycle.

## Configuration
- `ARRAY_SORT_SWAP_COUNT_EN`:
  - Defined: the 16-bit `swap_count` register is built. It saturates at 16'hFFFF and clears on start.
  - Undefined: no counter logic is built and `swap_count` is tied to 0. Sort behaviour and cycle timing are identical in both builds.

## Test plan
- Sorted input: `r[11..15]`={11,12,13,14,15}, `array`=11, `length`=5, `go`=1. Required: `done` at E0+5, contents unchanged, `swap_count`=0.
- Single swap: `r[2..6]`={1,2,3,2,5}, `array`=2, `length`=5. Required: result {1,2,2,3,5}, `swap_count`=1, `done` at E0+9.
- Large leading element: `r[22..26]`={5,2,3,4,5}, `array`=22, `length`=5. Required: result {2,3,4,5,5}, `swap_count`=3, and only two passes run.
- Wrap-around: `r[30]`=9, `r[31]`=8, `r[0]`=7, `r[1]`=6, `array`=30, `length`=4. Required: `r[30,31,0,1]`={6,7,8,9}, `swap_count`=6, and `r[2]` untouched.
- Degenerate lengths: `length`=0, then separately `length`=1. Required: `done` at E0 in both cases, no register writes, `swap_count`=0.
- Disturbance mid-sort:
  - `ext_we` to `r[23]` while `busy`=1: the write is ignored.
  - `reset`=0 held for one edge mid-sort: next cycle `busy`=0, `done`=0, state IDLE, and the array keeps its partially sorted contents.
  - A new `go` then completes the sort correctly.
